// File: rtl/mem_arbiter_rr_if.sv
// Request/ack bus between N masters, the arbiter and the shared HyperRAM controller.
// The master modport is the arbiter's view (it masters the RAM side); slave is the environment's view.
interface mem_arbiter_rr_if #(
  parameter int MASTERS = 4,
  parameter int ABITS   = 24,
  parameter int DBITS   = 8
);
  logic [MASTERS-1:0]       m_req;
  logic [MASTERS-1:0]       m_lock;
  logic [MASTERS-1:0]       m_we;
  logic [MASTERS*ABITS-1:0] m_a;
  logic [MASTERS*DBITS-1:0] m_d;
  logic [MASTERS-1:0]       m_ack;
  logic [MASTERS*DBITS-1:0] m_q;
  logic                     s_req;
  logic                     s_we;
  logic [ABITS-1:0]         s_a;
  logic [DBITS-1:0]         s_d;
  logic                     s_ack;
  logic [DBITS-1:0]         s_q;
  logic [2:0]               grant;

  modport master (
    input  m_req, m_lock, m_we, m_a, m_d, s_ack, s_q,
    output m_ack, m_q, s_req, s_we, s_a, s_d, grant
  );

  modport slave (
    output m_req, m_lock, m_we, m_a, m_d, s_ack, s_q,
    input  m_ack, m_q, s_req, s_we, s_a, s_d, grant
  );
endinterface

// File: rtl/mem_arbiter_rr.sv
// N-master to 1-slave HyperRAM arbiter: round-robin or fixed priority, lock affinity with burst cap.
// IDLE: arbitrate | BUSY: s_req held, wait s_ack | DONE: m_ack pulse, pointer/affinity update
module mem_arbiter_rr #(
  parameter int MASTERS   = 4,
  parameter int ABITS     = 24,
  parameter int DBITS     = 8,
  parameter int RR_MODE   = 1,
  parameter int MAX_BURST = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  mem_arbiter_rr_if.master   bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e             state_q, state_d;
  logic [2:0]         ptr_q, ptr_d, grant_q, grant_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               aff_q, aff_d, lock_q, lock_d, contend_q, contend_d;
  logic               s_req_q, s_req_d, s_we_q, s_we_d;
  logic [ABITS-1:0]   s_a_q, s_a_d;
  logic [DBITS-1:0]   s_d_q, s_d_d, q_q, q_d;
  logic [MASTERS-1:0] ack_q, ack_d;

  logic               any_req, other_req, win_lock, win_we, honour;
  logic [2:0]         win_idx, grant_nxt;
  logic [ABITS-1:0]   win_a;
  logic [DBITS-1:0]   win_d;

  always_comb begin : pick
    any_req   = |bus.m_req;
    other_req = 1'b0;
    win_idx   = 3'd0;
    win_lock  = 1'b0;
    win_we    = 1'b0;
    win_a     = '0;
    win_d     = '0;
    for (int i = MASTERS-1; i >= 0; i--) begin
      if (bus.m_req[i]) win_idx = 3'(i);
    end
    // Second pass overrides with the lowest requester at or above the pointer, else the wrap winner stands.
    if (RR_MODE != 0) begin
      for (int i = MASTERS-1; i >= 0; i--) begin
        if (bus.m_req[i] && (3'(i) >= ptr_q)) win_idx = 3'(i);
      end
    end else begin
      for (int i = 0; i < MASTERS; i++) begin
        if (aff_q && bus.m_req[i] && (3'(i) == grant_q)) win_idx = grant_q;
      end
    end
    for (int i = 0; i < MASTERS; i++) begin
      if (3'(i) == win_idx) begin
        win_lock = bus.m_lock[i];
        win_we   = bus.m_we[i];
        win_a    = bus.m_a[i*ABITS +: ABITS];
        win_d    = bus.m_d[i*DBITS +: DBITS];
      end
      if (bus.m_req[i] && (3'(i) != grant_q)) other_req = 1'b1;
    end
    grant_nxt = (grant_q == 3'(MASTERS-1)) ? 3'd0 : grant_q + 3'd1;
    honour    = lock_q && (!(contend_q || other_req) || (cnt_q < 8'(MAX_BURST-1)));
  end

  always_comb begin : fsm
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    aff_d     = aff_q;
    lock_d    = lock_q;
    contend_d = contend_q;
    s_req_d   = s_req_q;
    s_we_d    = s_we_q;
    s_a_d     = s_a_q;
    s_d_d     = s_d_q;
    q_d       = q_q;
    ack_d     = '0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d   = BUSY;
          grant_d   = win_idx;
          s_req_d   = 1'b1;
          s_we_d    = win_we;
          s_a_d     = win_a;
          s_d_d     = win_d;
          lock_d    = win_lock;
          contend_d = 1'b0;
          if (win_idx != grant_q) begin
            cnt_d = 8'd0;
            aff_d = 1'b0;
          end
        end
      end
      BUSY: begin
        if (other_req) contend_d = 1'b1;
        if (bus.s_ack) begin
          state_d = DONE;
          s_req_d = 1'b0;
          q_d     = bus.s_q;
          for (int i = 0; i < MASTERS; i++) ack_d[i] = (3'(i) == grant_q);
        end
      end
      DONE: begin
        state_d = IDLE;
        if (honour) begin
          ptr_d = grant_q;
          aff_d = 1'b1;
          cnt_d = cnt_q + 8'd1;
        end else begin
          ptr_d = grant_nxt;
          aff_d = 1'b0;
          cnt_d = 8'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ptr_q     <= 3'd0;
      grant_q   <= 3'd0;
      cnt_q     <= 8'd0;
      aff_q     <= 1'b0;
      lock_q    <= 1'b0;
      contend_q <= 1'b0;
      s_req_q   <= 1'b0;
      s_we_q    <= 1'b0;
      s_a_q     <= '0;
      s_d_q     <= '0;
      q_q       <= '0;
      ack_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      aff_q     <= aff_d;
      lock_q    <= lock_d;
      contend_q <= contend_d;
      s_req_q   <= s_req_d;
      s_we_q    <= s_we_d;
      s_a_q     <= s_a_d;
      s_d_q     <= s_d_d;
      q_q       <= q_d;
      ack_q     <= ack_d;
    end
  end

  assign bus.s_req = s_req_q;
  assign bus.s_we  = s_we_q;
  assign bus.s_a   = s_a_q;
  assign bus.s_d   = s_d_q;
  assign bus.m_ack = ack_q;
  assign bus.m_q   = {MASTERS{q_q}};
  assign bus.grant = grant_q;

endmodule
